adc_serial_cfg: RTL and testbench
=================================

ADC_SERIAL_CFG -- requirements
Module: adc_serial_cfg

Interface
REQ-001 The block SHALL take parameter N_ADC, default 12: number of ADC chip-select lines.
REQ-002 The block SHALL take parameter WORD_W, default 16: serial word length in bits.
REQ-003 The block SHALL take parameter CLK_DIV, default 4: CLK cycles per SCLK half-period, legal range >=1.
REQ-004 The block SHALL take parameter RST_CYCLES, default 8: width of the ADC reset pulse, in CLK cycles.
REQ-005 The block SHALL have port CLK, input, 1 bit: the single block clock, with all logic on its rising edge.
REQ-006 The block SHALL have port RST_B, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port START, input, 1 bit: single-cycle request for a write transaction.
REQ-008 The block SHALL have port SEQ_MODE, input, 1 bit: 0 = broadcast to all masked ADCs, 1 = one frame per masked ADC.
REQ-009 The block SHALL have port ADC_MASK, input, N_ADC bits: target ADCs, sampled when START is accepted.
REQ-010 The block SHALL have port WDATA, input, WORD_W bits: word to shift out, sampled when START is accepted.
REQ-011 The block SHALL have port RST_REQ, input, 1 bit: single-cycle request for an ADC hardware reset pulse.
REQ-012 The block SHALL have port BUSY, output, 1 bit: high while a transaction or reset pulse is in progress.
REQ-013 The block SHALL have port DONE, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port ADC_CS, output, N_ADC bits: active-high chip selects (the pad stage inverts them).
REQ-015 The block SHALL have ports ADC_RST, ADC_SCLK and ADC_SDATA, outputs, 1 bit each: active-high ADC reset, serial clock, serial data.

Function
REQ-016 The FSM SHALL have states IDLE, RSTP, SHIFT, HOLD, GAP and FIN.
REQ-017 In IDLE, RST_REQ SHALL have priority over START: if both are high in the same cycle, START is dropped.
REQ-018 RST_REQ accepted in IDLE SHALL move to RSTP: ADC_RST and BUSY high for exactly RST_CYCLES cycles, then FIN.
REQ-019 START accepted in IDLE with ADC_MASK != 0 SHALL latch ADC_MASK and WDATA and enter SHIFT on the next cycle.
REQ-020 START with ADC_MASK == 0 SHALL go directly to FIN: BUSY high for 1 cycle, no CS, SCLK or SDATA activity.
REQ-021 START and RST_REQ SHALL be ignored whenever BUSY=1; there is no queuing.
REQ-022 Target selection SHALL depend on SEQ_MODE: broadcast asserts all latched mask bits at once; sequential asserts only the lowest-index remaining bit for each frame.
REQ-023 SHIFT SHALL send each of the WORD_W bits, MSB first, as SCLK low for CLK_DIV cycles then SCLK high for CLK_DIV cycles.
REQ-024 SDATA SHALL change only at the start of each bit, i.e. on SCLK falling or at frame start, never while SCLK is high.
REQ-025 HOLD SHALL follow SHIFT for CLK_DIV cycles with SCLK low and CS still asserted.
REQ-026 GAP SHALL follow HOLD for CLK_DIV cycles with CS=0 and SCLK=0.
REQ-027 In sequential mode, GAP SHALL clear the served mask bit, then return to SHIFT for the next ADC, or go to FIN if no bits remain.
REQ-028 FIN SHALL last one cycle: DONE=1 and BUSY=0 in that cycle, then IDLE.
REQ-029 The divider and bit counters SHALL be sized as $clog2 of their maximum values, saturate-free, and reload at every state entry.
REQ-030 ADC_SDATA SHALL be 0 outside SHIFT/HOLD, and ADC_SCLK SHALL be 0 outside SHIFT.

Reset
REQ-031 RST_B low SHALL immediately force state IDLE and set BUSY, DONE, ADC_CS, ADC_RST, ADC_SCLK and ADC_SDATA to 0, even mid-frame or mid-pulse.
REQ-032 On RST_B release, the first accepted request SHALL be the first START or RST_REQ on or after the first rising CLK edge with RST_B high.
REQ-033 Reset SHALL NOT generate an ADC_RST pulse; the ADC reset pulse comes only from RST_REQ.

Verification (N_ADC=12, WORD_W=16, CLK_DIV=4, RST_CYCLES=8; START at cycle 0)
REQ-034 The bench SHALL check broadcast: SEQ_MODE=0, mask 0xFFF, WDATA 0xA5C3 -> ADC_CS=0xFFF in cycles 1-132, 16 SCLK rising edges at cycles 5+8k, SDATA bits 1010010111000011 MSB first, DONE=1 at cycle 137, BUSY=1 in cycles 1-136.
REQ-035 The bench SHALL check sequential: SEQ_MODE=1, mask 0x005 -> ADC_CS=0x001 in cycles 1-132, then 0x004 in cycles 137-268, DONE at cycle 273, never two CS bits high at once.
REQ-036 The bench SHALL check reset pulse: RST_REQ at cycle 0 -> ADC_RST=1 in cycles 1-8, DONE at cycle 9, CS/SCLK stay 0.
REQ-037 The bench SHALL check simultaneous and ignored requests: START and RST_REQ together -> reset pulse only; START at cycle 50 of a broadcast -> ignored, and DONE still occurs exactly once at cycle 137.
REQ-038 The bench SHALL check empty mask: START with mask 0 -> BUSY=1 at cycle 1, DONE at cycle 2, all ADC pins stay 0.
REQ-039 The bench SHALL check async reset: RST_B low at cycle 40 of a broadcast -> all outputs 0 in the same cycle; a new START after release runs a full, correct 137-cycle transaction.

Source files
------------

// File: rtl/adc_serial_cfg_if.sv
// Request/status and ADC pin bundle for adc_serial_cfg.
// master = requester side, slave = the serializer.
interface adc_serial_cfg_if #(
  parameter int N_ADC  = 12,
  parameter int WORD_W = 16
);
  logic              START;
  logic              SEQ_MODE;
  logic [N_ADC-1:0]  ADC_MASK;
  logic [WORD_W-1:0] WDATA;
  logic              RST_REQ;
  logic              BUSY;
  logic              DONE;
  logic [N_ADC-1:0]  ADC_CS;
  logic              ADC_RST;
  logic              ADC_SCLK;
  logic              ADC_SDATA;

  modport master (
    output START, SEQ_MODE, ADC_MASK, WDATA, RST_REQ,
    input  BUSY, DONE, ADC_CS, ADC_RST, ADC_SCLK, ADC_SDATA
  );
  modport slave (
    input  START, SEQ_MODE, ADC_MASK, WDATA, RST_REQ,
    output BUSY, DONE, ADC_CS, ADC_RST, ADC_SCLK, ADC_SDATA
  );
endinterface

// File: rtl/adc_serial_cfg.sv
// Serial write engine for a bank of ADCs: broadcast or per-ADC frames,
// MSB-first words on a divided SCLK, plus a timed ADC reset pulse.
module adc_serial_cfg #(
  parameter int N_ADC      = 12,
  parameter int WORD_W     = 16,
  parameter int CLK_DIV    = 4,
  parameter int RST_CYCLES = 8
) (
  input logic             CLK,
  input logic             RST_B,
  adc_serial_cfg_if.slave bus
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LOAD = BW'(WORD_W - 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RSTP, SHIFT, HOLD, GAP, FIN} state_t;

  state_t            state, state_nx;
  logic [DW-1:0]     div_cnt;
  logic              phase;
  logic [BW-1:0]     bit_cnt;
  logic [RW-1:0]     rst_cnt;
  logic [WORD_W-1:0] wdata_q, shreg;
  logic [N_ADC-1:0]  mask_q, low_bit, mask_rem;
  logic              seq_q;
  logic              div_end, bit_last, rst_end;

  assign div_end  = (div_cnt == '0);
  assign bit_last = (bit_cnt == '0);
  assign rst_end  = (rst_cnt == '0);
  assign low_bit  = mask_q & (~mask_q + 1'b1);
  assign mask_rem = mask_q & ~low_bit;

  always_ff @(posedge CLK or negedge RST_B)
    if (!RST_B) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.RST_REQ)    state_nx = RSTP;
             else if (bus.START) state_nx = (bus.ADC_MASK != '0) ? SHIFT : GAP;
      RSTP:  if (rst_end) state_nx = FIN;
      SHIFT: if (div_end && phase && bit_last) state_nx = HOLD;
      HOLD:  if (div_end) state_nx = GAP;
      GAP:   if (div_end) state_nx = (seq_q && mask_rem != '0) ? SHIFT : FIN;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Counters reload on every state change; an empty-mask request passes
  // through GAP for a single cycle so BUSY is seen before DONE.
  always_ff @(posedge CLK or negedge RST_B)
    if (!RST_B) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      rst_cnt <= '0;
      wdata_q <= '0;
      shreg   <= '0;
      mask_q  <= '0;
      seq_q   <= 1'b0;
    end else if (state_nx != state) begin
      div_cnt <= (state == IDLE && state_nx == GAP) ? '0 : DIV_LOAD;
      phase   <= 1'b0;
      bit_cnt <= BIT_LOAD;
      rst_cnt <= RST_LOAD;
      if (state == IDLE && state_nx != RSTP) begin
        mask_q  <= bus.ADC_MASK;
        seq_q   <= bus.SEQ_MODE;
        wdata_q <= bus.WDATA;
        shreg   <= bus.WDATA;
      end
      if (state == GAP) begin
        mask_q <= mask_rem;
        shreg  <= wdata_q;
      end
    end else begin
      unique case (state)
        SHIFT: if (div_end) begin
                 div_cnt <= DIV_LOAD;
                 phase   <= ~phase;
                 // next bit only after the high half, i.e. on SCLK fall
                 if (phase) begin
                   bit_cnt <= bit_cnt - 1'b1;
                   shreg   <= {shreg[WORD_W-2:0], 1'b0};
                 end
               end else begin
                 div_cnt <= div_cnt - 1'b1;
               end
        HOLD, GAP: div_cnt <= div_cnt - 1'b1;
        RSTP:      rst_cnt <= rst_cnt - 1'b1;
        default: ;
      endcase
    end

  always_comb begin
    bus.BUSY      = (state != IDLE) && (state != FIN);
    bus.DONE      = (state == FIN);
    bus.ADC_RST   = (state == RSTP);
    bus.ADC_SCLK  = (state == SHIFT) && phase;
    bus.ADC_SDATA = 1'b0;
    bus.ADC_CS    = '0;
    if (state == SHIFT || state == HOLD) begin
      bus.ADC_SDATA = shreg[WORD_W-1];
      bus.ADC_CS    = seq_q ? low_bit : mask_q;
    end
  end
endmodule

// File: tb/tb_adc_serial_cfg.sv
// Scoreboard bench: per-cycle expected pin states are queued when a request
// is driven and popped against the DUT one cycle at a time.
module tb_adc_serial_cfg;
  localparam int NA = 12, W = 16, D = 4, RC = 8;
  localparam int SH = 2 * D * W;
  localparam int FR = SH + 2 * D;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [NA-1:0] cs;
    logic          rst;
    logic          sclk;
    logic          sdata;
  } obs_t;

  logic CLK = 1'b0;
  logic RST_B = 1'b0;
  int   vectors = 0;
  int   errors = 0;
  obs_t exp_q[$];
  bit   dc_q[$];

  adc_serial_cfg_if #(.N_ADC(NA), .WORD_W(W)) bus();

  adc_serial_cfg #(.N_ADC(NA), .WORD_W(W), .CLK_DIV(D), .RST_CYCLES(RC)) dut (
    .CLK(CLK), .RST_B(RST_B), .bus(bus)
  );

  always #5 CLK = ~CLK;

  function automatic obs_t observe();
    observe = '{busy: bus.BUSY, done: bus.DONE, cs: bus.ADC_CS,
                rst: bus.ADC_RST, sclk: bus.ADC_SCLK, sdata: bus.ADC_SDATA};
  endfunction

  function automatic logic [NA-1:0] nth_bit(logic [NA-1:0] m, int n);
    int c = 0;
    nth_bit = '0;
    for (int i = 0; i < NA; i++)
      if (m[i]) begin
        if (c == n) nth_bit[i] = 1'b1;
        c++;
      end
  endfunction

  // kind 0: write transaction, 1: reset pulse, 2: idle
  function automatic obs_t model(int kind, bit seq, logic [NA-1:0] mask,
                                 logic [W-1:0] wd, int k, output bit dc);
    obs_t o = '0;
    int nfr, total, f, t;
    dc = 1'b0;
    if (kind == 1) begin
      o.busy = (k >= 1 && k <= RC);
      o.rst  = o.busy;
      o.done = (k == RC + 1);
    end else if (kind == 0 && mask == '0) begin
      o.busy = (k == 1);
      o.done = (k == 2);
    end else if (kind == 0) begin
      nfr    = seq ? $countones(mask) : 1;
      total  = FR * nfr;
      o.busy = (k >= 1 && k <= total);
      o.done = (k == total + 1);
      if (o.busy) begin
        f = (k - 1) / FR;
        t = (k - 1) % FR;
        if (t < SH + D) o.cs = seq ? nth_bit(mask, f) : mask;
        if (t < SH) begin
          o.sclk  = ((t % (2 * D)) >= D);
          o.sdata = wd[W - 1 - t / (2 * D)];
        end else if (t < SH + D) begin
          dc = 1'b1;
        end
      end
    end
    return o;
  endfunction

  task automatic push_exp(int kind, bit seq, logic [NA-1:0] mask, logic [W-1:0] wd, int n);
    obs_t o;
    bit dc;
    for (int k = 1; k <= n; k++) begin
      o = model(kind, seq, mask, wd, k, dc);
      exp_q.push_back(o);
      dc_q.push_back(dc);
    end
  endtask

  // Drive a request during "cycle 0" (sampled at the next rising edge).
  task automatic kick(bit start, bit rreq, bit seq, logic [NA-1:0] mask, logic [W-1:0] wd);
    @(negedge CLK);
    bus.START    = start;
    bus.RST_REQ  = rreq;
    bus.SEQ_MODE = seq;
    bus.ADC_MASK = mask;
    bus.WDATA    = wd;
  endtask

  // Check n cycles; optionally pulse START (inj) and RST_REQ (inj+10) while busy.
  task automatic run_check(string name, int n, int inj);
    obs_t e, g;
    bit dc;
    for (int k = 1; k <= n; k++) begin
      @(posedge CLK);
      #1;
      bus.START   = 1'b0;
      bus.RST_REQ = 1'b0;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s cycle %0d: scoreboard empty, expected entry required", name, k);
        continue;
      end
      e  = exp_q.pop_front();
      dc = dc_q.pop_front();
      g  = observe();
      if (dc) g.sdata = e.sdata;
      vectors++;
      if (g !== e || $countones(g.cs) > (e.cs == '0 ? 0 : $countones(e.cs))) begin
        errors++;
        $display("FAIL %s cycle %0d: got busy=%b done=%b cs=%h rst=%b sclk=%b sd=%b, want busy=%b done=%b cs=%h rst=%b sclk=%b sd=%b",
                 name, k, g.busy, g.done, g.cs, g.rst, g.sclk, g.sdata,
                 e.busy, e.done, e.cs, e.rst, e.sclk, e.sdata);
      end
      if (k == inj) begin
        bus.START    = 1'b1;
        bus.ADC_MASK = 12'h00F;
        bus.WDATA    = 16'hFFFF;
        bus.SEQ_MODE = 1'b1;
      end
      if (inj > 0 && k == inj + 10) bus.RST_REQ = 1'b1;
    end
  endtask

  task automatic check_zero(string name);
    obs_t g = observe();
    vectors++;
    if (g !== obs_t'(0)) begin
      errors++;
      $display("FAIL %s: got outputs %h, want all 0", name, g);
    end
  endtask

  task automatic test_reset();
    #1 check_zero("reset_hold");
    @(posedge CLK); #1 check_zero("reset_hold_edge");
    @(negedge CLK);
    RST_B = 1'b1;
    push_exp(2, 1'b0, '0, '0, 6);
    run_check("reset_release_idle", 6, 0);
  endtask

  task automatic test_broadcast();
    kick(1'b1, 1'b0, 1'b0, 12'hFFF, 16'hA5C3);
    push_exp(0, 1'b0, 12'hFFF, 16'hA5C3, FR + 3);
    run_check("broadcast", FR + 3, 0);
  endtask

  task automatic test_sequential(logic [NA-1:0] mask, logic [W-1:0] wd);
    int n = FR * $countones(mask) + 3;
    kick(1'b1, 1'b0, 1'b1, mask, wd);
    push_exp(0, 1'b1, mask, wd, n);
    run_check("sequential", n, 0);
  endtask

  task automatic test_rst_pulse();
    kick(1'b0, 1'b1, 1'b0, 12'h0F0, 16'h1234);
    push_exp(1, 1'b0, '0, '0, RC + 3);
    run_check("rst_pulse", RC + 3, 0);
  endtask

  task automatic test_simultaneous();
    kick(1'b1, 1'b1, 1'b0, 12'hFFF, 16'hFFFF);
    push_exp(1, 1'b0, '0, '0, RC + 3);
    run_check("start_and_rst_req", RC + 3, 0);
  endtask

  task automatic test_ignored();
    kick(1'b1, 1'b0, 1'b0, 12'h3C1, 16'h0F0F);
    push_exp(0, 1'b0, 12'h3C1, 16'h0F0F, FR + 3);
    run_check("ignored_requests", FR + 3, 50);
  endtask

  task automatic test_empty_mask();
    kick(1'b1, 1'b0, 1'b1, 12'h000, 16'hBEEF);
    push_exp(0, 1'b1, 12'h000, 16'hBEEF, 5);
    run_check("empty_mask", 5, 0);
  endtask

  task automatic test_async_reset();
    kick(1'b1, 1'b0, 1'b0, 12'hFFF, 16'h5A3C);
    push_exp(0, 1'b0, 12'hFFF, 16'h5A3C, FR + 3);
    run_check("async_pre", 40, 0);
    #2 RST_B = 1'b0;
    #1 check_zero("async_assert");
    exp_q.delete();
    dc_q.delete();
    @(posedge CLK); #1 check_zero("async_held");
    @(negedge CLK);
    RST_B        = 1'b1;
    bus.START    = 1'b1;
    bus.RST_REQ  = 1'b0;
    bus.SEQ_MODE = 1'b0;
    bus.ADC_MASK = 12'h801;
    bus.WDATA    = 16'hC001;
    push_exp(0, 1'b0, 12'h801, 16'hC001, FR + 3);
    run_check("async_after_release", FR + 3, 0);
  endtask

  task automatic test_back_to_back();
    kick(1'b1, 1'b0, 1'b1, 12'h090, 16'h8001);
    bus.START = 1'b1;
    push_exp(0, 1'b1, 12'h090, 16'h8001, 2 * FR + 2);
    run_check("b2b_first", 2 * FR + 2, 0);
    bus.START    = 1'b1;
    bus.SEQ_MODE = 1'b0;
    bus.ADC_MASK = 12'h402;
    bus.WDATA    = 16'h7FFE;
    push_exp(0, 1'b0, 12'h402, 16'h7FFE, FR + 3);
    run_check("b2b_second", FR + 3, 0);
  endtask

  initial begin
    bus.START    = 1'b0;
    bus.RST_REQ  = 1'b0;
    bus.SEQ_MODE = 1'b0;
    bus.ADC_MASK = '0;
    bus.WDATA    = '0;
    test_reset();
    test_broadcast();
    test_sequential(12'h005, 16'hA5C3);
    test_sequential(12'hA40, 16'h3C96);
    test_rst_pulse();
    test_simultaneous();
    test_ignored();
    test_empty_mask();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
